adder_pipe_param: RTL and testbench

Parametrised pipelined adder/subtractor that splits a WIDTH-bit operation into SLICE-bit ripple slices, one slice per pipeline stage, with the inter-slice carry registered between stages. It extends the fixed 16-bit four-stage carry-pipelined adder with:
- configurable width and slice size,
- a valid-qualified data path,
- a global stall enable,
- carry-out and optional signed-overflow reporting.

It sits in the CORDIC iteration datapath and any accumulate path needing full throughput at high clock rate.

---
 rtl/adder_pipe_param.sv | 118 +++++++++++
 tb/tb_adder_pipe_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_param.sv
// Pipelined adder/subtractor: one SLICE-bit ripple slice per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe_param #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic             sign,
    output logic             out_valid,
    output logic [WIDTH-1:0] b,
    output logic             carry_out
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / SLICE;

    logic [WIDTH-1:0] w_a2Eff;

    assign w_a2Eff = sign ? ~a2 : a2;

`ifdef ADDER_PIPE_OVF_EN
    logic w_ovfNext;
    logic r_ovf;
`endif

    // Each stage consumes the low slice of its operands and forwards only the
    // not-yet-added upper bits, so the operand skew shrinks as the sum grows.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int IN_W = WIDTH - s * SLICE;

        logic [IN_W-1:0]          w_inA;
        logic [IN_W-1:0]          w_inB;
        logic                     w_inC;
        logic                     w_inValid;
        logic [SLICE:0]           w_slice;
        logic [(s+1)*SLICE-1:0]   w_nextSum;
        logic [(s+1)*SLICE-1:0]   r_sum;
        logic                     r_carry;
        logic                     r_valid;

        if (s == 0) begin : g_first
            assign w_inA     = a1;
            assign w_inB     = w_a2Eff;
            assign w_inC     = sign;
            assign w_inValid = in_valid;
            assign w_nextSum = w_slice[SLICE-1:0];
        end else begin : g_rest
            assign w_inA     = g_stage[s-1].g_keep.r_opA;
            assign w_inB     = g_stage[s-1].g_keep.r_opB;
            assign w_inC     = g_stage[s-1].r_carry;
            assign w_inValid = g_stage[s-1].r_valid;
            assign w_nextSum = {w_slice[SLICE-1:0], g_stage[s-1].r_sum};
        end

        assign w_slice = {1'b0, w_inA[SLICE-1:0]}
                       + {1'b0, w_inB[SLICE-1:0]}
                       + {{SLICE{1'b0}}, w_inC};

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
                r_valid <= 1'b0;
            end else if (en) begin
                r_sum   <= w_nextSum;
                r_carry <= w_slice[SLICE];
                r_valid <= w_inValid;
            end
        end

        if (s < STAGES - 1) begin : g_keep
            logic [IN_W-SLICE-1:0] r_opA;
            logic [IN_W-SLICE-1:0] r_opB;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_opA <= '0;
                    r_opB <= '0;
                end else if (en) begin
                    r_opA <= w_inA[IN_W-1:SLICE];
                    r_opB <= w_inB[IN_W-1:SLICE];
                end
            end
        end

`ifdef ADDER_PIPE_OVF_EN
        // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
        if (s == STAGES - 1) begin : g_last
            assign w_ovfNext = w_inA[SLICE-1] ^ w_inB[SLICE-1] ^ w_slice[SLICE-1] ^ w_slice[SLICE];
        end
`endif
    end

`ifdef ADDER_PIPE_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (en) begin
            r_ovf <= w_ovfNext;
        end
    end

    assign ovf = r_ovf;
`endif

    assign b         = g_stage[STAGES-1].r_sum;
    assign carry_out = g_stage[STAGES-1].r_carry;
    assign out_valid = g_stage[STAGES-1].r_valid;

endmodule

// File: tb/tb_adder_pipe_param.sv
// Self-checking bench for adder_pipe_param (WIDTH=16, SLICE=4): scoreboard queue plus per-scenario checks.
module tb_adder_pipe_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [15:0] a1;
    logic [15:0] a2;
    logic        sign;
    logic        out_valid;
    logic [15:0] b;
    logic        carry_out;
`ifdef ADDER_PIPE_OVF_EN
    logic        ovf;
`endif

    typedef struct {
        logic [15:0] b;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sbQ[$];
    int   testsRun = 0;
    int   failures = 0;
    int   enCnt = 0;
    logic lastEn = 1'b0;

    adder_pipe_param #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .a1        (a1),
        .a2        (a2),
        .sign      (sign),
        .out_valid (out_valid),
        .b         (b),
        .carry_out (carry_out)
`ifdef ADDER_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // enCnt counts enabled edges only, so stalls do not count against latency.
    always @(posedge clk) begin
        lastEn <= reset && en;
        if (reset && en) enCnt <= enCnt + 1;
    end

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t        e;
        logic [16:0] full;
        full   = s ? ({1'b0, x} - {1'b0, y} + 17'h10000) : ({1'b0, x} + {1'b0, y});
        e.b    = full[15:0];
        e.cout = full[16];
        if (s) e.ovf = (x[15] != y[15]) && (full[15] != x[15]);
        else   e.ovf = (x[15] == y[15]) && (full[15] != x[15]);
        e.due  = 0;
        return e;
    endfunction

    // A fresh result appears only after an enabled edge; a held output is not re-counted.
    always @(negedge clk) begin
        if (reset && lastEn && out_valid) begin
            testsRun++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_output b=%h carry_out=%b (nothing expected)", b, carry_out);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                if (b !== e.b || carry_out !== e.cout || enCnt !== e.due
`ifdef ADDER_PIPE_OVF_EN
                    || ovf !== e.ovf
`endif
                   ) begin
                    failures++;
                    $display("[TB] FAIL result: got b=%h cout=%b edge=%0d, expected b=%h cout=%b ovf=%b edge=%0d",
                             b, carry_out, enCnt, e.b, e.cout, e.ovf, e.due);
                end
            end
        end
    end

    task automatic driveOp(input logic v, input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t e;
        @(negedge clk);
        en       = 1'b1;
        in_valid = v;
        a1       = x;
        a2       = y;
        sign     = s;
        if (v) begin
            e     = model(x, y, s);
            e.due = enCnt + 4;
            sbQ.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            en       = 1'b1;
            n++;
        end
        testsRun++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic checkValid(input string name, input logic expected);
        testsRun++;
        if (out_valid !== expected) begin
            failures++;
            $display("[TB] FAIL %s: out_valid=%b, required %b", name, out_valid, expected);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; in_valid = 1'b0; a1 = '0; a2 = '0; sign = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (b !== 16'h0 || carry_out !== 1'b0 || out_valid !== 1'b0
`ifdef ADDER_PIPE_OVF_EN
            || ovf !== 1'b0
`endif
           ) begin
            failures++;
            $display("[TB] FAIL reset_state: b=%h cout=%b out_valid=%b, required 0/0/0", b, carry_out, out_valid);
        end
        reset = 1'b1;
    endtask

    task automatic test_plain_add();
        driveOp(1'b1, 16'h1234, 16'h0FFF, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkValid($sformatf("plain_add_valid_cycle%0d", k), k == 4);
        end
        drain();
    endtask

    task automatic test_carry_ripple();
        driveOp(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        driveOp(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        drain();
    endtask

    task automatic test_subtract();
        driveOp(1'b1, 16'h0005, 16'h0007, 1'b1);
        driveOp(1'b1, 16'h8000, 16'h0001, 1'b1);
        driveOp(1'b1, 16'h1234, 16'h1234, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic pattern [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++)
            driveOp(pattern[i], 16'($urandom), 16'($urandom), 1'($urandom));
        checkValid("bubble_pattern0", pattern[0]);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkValid($sformatf("bubble_pattern%0d", k), pattern[k]);
        end
        drain();
    endtask

    task automatic test_stall();
        logic [15:0] frozen;
        for (int i = 0; i < 4; i++)
            driveOp(1'b1, 16'h1000 + 16'(i * 16'h0111), 16'h0F0F + 16'(i), 1'(i));
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; a1 = 16'hDEAD; a2 = 16'hBEEF;
        checkValid("stall_first_result", 1'b1);
        frozen = b;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            testsRun++;
            if (out_valid !== 1'b1 || b !== frozen) begin
                failures++;
                $display("[TB] FAIL stall_frozen%0d: b=%h out_valid=%b, required b=%h out_valid=1", k, b, out_valid, frozen);
            end
        end
        en = 1'b1; in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkValid($sformatf("stall_resume%0d", k), k <= 3);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        driveOp(1'b1, 16'h1234, 16'h0FFF, 1'b0);
        driveOp(1'b1, 16'h4321, 16'h1111, 1'b0);
        driveOp(1'b1, 16'h9000, 16'h0001, 1'b1);
        driveOp(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checkValid("midstream_before_reset", 1'b1);
        #2 reset = 1'b0;
        #1;
        testsRun++;
        if (b !== 16'h0 || carry_out !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: b=%h cout=%b out_valid=%b, required 0/0/0", b, carry_out, out_valid);
        end
        sbQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkValid($sformatf("post_reset_idle%0d", k), 1'b0);
        end
        driveOp(1'b1, 16'h0102, 16'h0304, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkValid($sformatf("post_reset_latency%0d", k), k == 4);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_plain_add();
        test_carry_ripple();
        test_subtract();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
